// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// default latencies, FSM states and the HI/LO payload type.
package mdu_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101,
    MDU_NOP6  = 3'b110,
    MDU_NOP7  = 3'b111
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // mult/multu/div/divu all have a clear top opcode bit
  function automatic logic is_md_op(input mdu_op_e op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the next {hi, lo}.
// A zero divisor leaves the current HI/LO in place.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  hilo_t           cur,
  output hilo_t           res_c
);

  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_u;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   div_s_b;
  logic [XLEN-1:0]   div_u_b;
  logic [XLEN-1:0]   q_mag;
  logic [XLEN-1:0]   r_mag;
  logic [XLEN-1:0]   q_s;
  logic [XLEN-1:0]   r_s;
  logic [XLEN-1:0]   q_u;
  logic [XLEN-1:0]   r_u;
  logic              b_zero;

  // Signed divide works on magnitudes, so 0x80000000 / -1 wraps to 0x80000000
  always_comb begin
    prod_s  = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
    prod_u  = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    b_zero  = (b == '0);
    mag_a   = a[XLEN-1] ? XLEN'(-a) : a;
    mag_b   = b[XLEN-1] ? XLEN'(-b) : b;
    div_s_b = b_zero ? XLEN'(1) : mag_b;
    div_u_b = b_zero ? XLEN'(1) : b;
    q_mag   = mag_a / div_s_b;
    r_mag   = mag_a % div_s_b;
    q_s     = (a[XLEN-1] ^ b[XLEN-1]) ? XLEN'(-q_mag) : q_mag;
    r_s     = a[XLEN-1] ? XLEN'(-r_mag) : r_mag;
    q_u     = a / div_u_b;
    r_u     = a % div_u_b;

    res_c = cur;
    case (op)
      MDU_MULT:  res_c = hilo_t'(prod_s);
      MDU_MULTU: res_c = hilo_t'(prod_u);
      MDU_DIV: begin
        if (!b_zero) begin
          res_c.hi = r_s;
          res_c.lo = q_s;
        end
      end
      MDU_DIVU: begin
        if (!b_zero) begin
          res_c.hi = r_u;
          res_c.lo = q_u;
        end
      end
      default: res_c = cur;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Execute-stage multiply/divide unit: fixed-latency mult/div sequencing,
// mthi/mtlo, and the HI/LO architectural registers.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            mdu_start,
  input  logic [2:0]      mdu_mod,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  hilo_t            hilo_q, hilo_d;
  hilo_t            shadow_q, shadow_d;
  hilo_t            arith_c;
  mdu_op_e          op;

  assign op = mdu_op_e'(mdu_mod);

  mdu_arith u_arith (
    .op    (op),
    .a     (a),
    .b     (b),
    .cur   (hilo_q),
    .res_c (arith_c)
  );

  // Next-state: results are parked in the shadow until the counter expires
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    hilo_d   = hilo_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (mdu_start && is_md_op(op)) begin
          shadow_d = arith_c;
          cnt_d    = (op == MDU_MULT || op == MDU_MULTU) ? CNT_W'(MULT_CYCLES)
                                                         : CNT_W'(DIV_CYCLES);
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end else if (!mdu_start) begin
          if (op == MDU_MTHI) begin
            hilo_d.hi = a;
          end else if (op == MDU_MTLO) begin
            hilo_d.lo = a;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hilo_d  = shadow_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hilo_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hilo_q   <= hilo_d;
      shadow_q <= shadow_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hilo_q.hi;
  assign lo   = hilo_q.lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, hand-written corner
// sequences and randomized operations against a 64-bit arithmetic model.
module tb_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        resetn;
  logic        mdu_start;
  logic [2:0]  mdu_mod;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  typedef struct {
    logic        start;
    logic [2:0]  mod;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[10];

  mdu dut (
    .clk       (clk),
    .resetn    (resetn),
    .mdu_start (mdu_start),
    .mdu_mod   (mdu_mod),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics via plain 64-bit arithmetic
  function automatic logic [63:0] ref_op(input logic st, input logic [2:0] md,
                                         input logic [31:0] oa, input logic [31:0] ob,
                                         input logic [31:0] h, input logic [31:0] l);
    int ia, ib;
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, pu, qu, ru;
    ia = oa; ib = ob;
    sa = ia; sb = ib;
    ua = oa; ub = ob;
    if (st && md < 3'd4) begin
      case (md)
        3'd0: begin p = sa * sb; return p; end
        3'd1: begin pu = ua * ub; return pu; end
        3'd2: begin
          if (ob == 0) return {h, l};
          q = sa / sb; r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        default: begin
          if (ob == 0) return {h, l};
          qu = ua / ub; ru = ua % ub;
          return {ru[31:0], qu[31:0]};
        end
      endcase
    end
    if (!st && md == 3'd4) return {oa, l};
    if (!st && md == 3'd5) return {h, oa};
    return {h, l};
  endfunction

  // Issue one command just after a falling edge, then follow it to completion
  task automatic do_op(input logic st, input logic [2:0] md, input logic [31:0] oa,
                       input logic [31:0] ob, input logic [31:0] eh, input logic [31:0] el,
                       input string nm, input bit inject);
    int n, cnt;
    mdu_start = st; mdu_mod = md; a = oa; b = ob;
    @(negedge clk);
    mdu_start = 1'b0; mdu_mod = 3'b110;
    if (st && md < 3'd4) begin
      n = (md < 3'd2) ? MULT_N : DIV_N;
      cnt = 0;
      for (int i = 0; i < n; i++) begin
        if (busy === 1'b1) cnt++;
        chk({nm, ".hi_hold"}, hi, cur_hi);
        chk({nm, ".lo_hold"}, lo, cur_lo);
        if (inject) begin
          if (i == 1) begin mdu_start = 1'b1; mdu_mod = 3'b101; a = 32'h999; end
          if (i == 2) begin mdu_start = 1'b1; mdu_mod = 3'b000; a = 1; b = 1; end
          if (i == 3) begin mdu_start = 1'b0; mdu_mod = 3'b100; a = 32'h777; end
          if (i == 4) begin mdu_start = 1'b0; mdu_mod = 3'b110; end
        end
        @(negedge clk);
      end
      chk({nm, ".busy_cycles"}, 32'(cnt), 32'(n));
    end
    chk({nm, ".busy_end"}, 32'(busy), 32'd0);
    chk({nm, ".hi"}, hi, eh);
    chk({nm, ".lo"}, lo, el);
    cur_hi = eh; cur_lo = el;
  endtask

  initial begin
    logic [63:0] e;
    logic        st;
    logic [2:0]  md;
    logic [31:0] ra, rb;
    int          sel, cnt;

    total = 0; bad = 0;
    cur_hi = 0; cur_lo = 0;
    mdu_start = 0; mdu_mod = 3'b110; a = 0; b = 0;
    resetn = 1'b0;

    vecs[0] = '{1'b1, 3'b000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{1'b1, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{1'b1, 3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{1'b1, 3'b011, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
    vecs[4] = '{1'b0, 3'b100, 32'h11,       32'd0,        32'h00000011, 32'h7FFFFFFC};
    vecs[5] = '{1'b0, 3'b101, 32'h22,       32'd0,        32'h00000011, 32'h00000022};
    vecs[6] = '{1'b1, 3'b011, 32'h5,        32'd0,        32'h00000011, 32'h00000022};
    vecs[7] = '{1'b1, 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[8] = '{1'b0, 3'b100, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'h80000000};
    vecs[9] = '{1'b1, 3'b110, 32'h1234,     32'h5678,     32'hDEADBEEF, 32'h80000000};

    repeat (2) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.hi", hi, 32'd0);
    chk("reset.lo", lo, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      do_op(vecs[i].start, vecs[i].mod, vecs[i].va, vecs[i].vb,
            vecs[i].eh, vecs[i].el, $sformatf("vec%0d", i), 1'b0);

    // Commands arriving while RUN must not disturb the in-flight mult
    do_op(1'b1, 3'b000, 32'd6, 32'd7, 32'd0, 32'd42, "ignored_in_run", 1'b1);

    // Async reset in the third busy cycle of a div
    mdu_start = 1'b1; mdu_mod = 3'b010; a = 32'd100; b = 32'd7;
    @(negedge clk);
    mdu_start = 1'b0; mdu_mod = 3'b110;
    repeat (2) @(negedge clk);
    chk("midrst.busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.hi", hi, 32'd0);
    chk("midrst.lo", lo, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < DIV_N + 2; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) cnt++;
    end
    chk("midrst.no_late_wb", 32'(cnt), 32'd0);
    cur_hi = 0; cur_lo = 0;
    do_op(1'b1, 3'b000, 32'hFFFFFFF0, 32'd16, 32'hFFFFFFFF, 32'hFFFFFF00, "post_rst_mult", 1'b0);

    // Randomized operations against the reference model
    for (int k = 0; k < 40; k++) begin
      md = 3'($urandom_range(0, 7));
      st = (md < 3'd4) ? ($urandom_range(0, 4) != 0) : 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 0;
      else if (sel == 1) rb = 32'hFFFFFFFF;
      else if (sel == 2) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (sel == 3) rb = 32'($urandom_range(1, 9));
      e = ref_op(st, md, ra, rb, cur_hi, cur_lo);
      do_op(st, md, ra, rb, e[63:32], e[31:0], $sformatf("rand%0d", k), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the execute stage of the pipelined MIPS core. Consumes the `mdu_mod` / `mdu_start` controls and the two forwarded register operands of the E-stage instruction. Runs mult/multu/div/divu as fixed-latency multi-cycle operations and handles mthi/mtlo. Holds the HI/LO architectural registers and exposes `busy` so the hazard logic can stall md-class instructions in D.

## Interface
- `MULT_CYCLES`, 5: cycles `busy` stays high for mult/multu.
- `DIV_CYCLES`, 10: cycles `busy` stays high for div/divu.
- `clk  in  1`: system clock; all state changes on the rising edge.
- `resetn  in  1`: reset, asynchronous, active-low.
- `mdu_start  in  1`: E-stage instruction is mult/multu/div/divu.
- `mdu_mod  in  3`: operation select.
  - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
  - 110 and 111 are no-op.
- `a  in  32`: rs value, forwarded.
- `b  in  32`: rt value, forwarded.
- `busy  out  1`: operation in flight.
- `hi  out  32`: HI register.
- `lo  out  32`: LO register.

## Operation
- State machine: IDLE, RUN.
- Reset (async, `resetn`=0): `hi`=0, `lo`=0, `busy`=0, counter=0, state IDLE, shadow registers=0. Applies immediately, including mid-operation; the in-flight result is discarded.
- IDLE, `mdu_start`=1, mod 000..011:
  - Capture the result into shadow registers `hi_nx`/`lo_nx`.
  - Load counter with N (`MULT_CYCLES` or `DIV_CYCLES`); go to RUN.
- Arithmetic:
  - mult: {hi,lo} = signed a × signed b (64-bit).
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of `a`. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - Divisor 0: the shadow registers take the current hi/lo, so hi/lo are unchanged; timing is unchanged.
- IDLE, `mdu_start`=0:
  - mod 100: hi ← a on this edge.
  - mod 101: lo ← a on this edge.
  - No busy in either case.
- RUN: counter decrements each edge. On the edge where the counter goes 1→0: hi/lo ← shadow, `busy` ← 0, state → IDLE.
- While RUN:
  - `mdu_start` and mthi/mtlo are ignored entirely.
  - Hazard logic guarantees none arrive; the bench checks they have no effect.
- `mdu_start`=1 with mod 100..111: treated as no-op.

## Timing
- Start accepted on edge E0. `busy`=1 from E0 through EN, i.e. exactly N cycles.
- hi/lo hold their old values until EN, when they update.
- `busy` drops and new hi/lo are visible in the same cycle.
- `busy` is registered. In the start cycle itself `busy`=0, so the hazard unit must stall on `is_md_instr_D && (mdu_start_E || busy)`.
- mthi/mtlo: 1-cycle, visible after the next edge.
- `hi`/`lo` are direct register outputs with no combinational path from inputs.
- Back-to-back: a new start is accepted in the first cycle `busy`=0 after completion, so the minimum start spacing is N+1 cycles.

## Structure
- The shared define file gains:
  - the `mdu_*` operation codes above;
  - `MULT_CYCLES` / `DIV_CYCLES` defaults.
- One sub-module, `mdu_arith`: combinational, `mdu_mod`/a/b → 64-bit {hi_nx, lo_nx}, including the divide-by-zero and signed-overflow rules.
- The top level holds the FSM, counter, shadow and architectural registers.

## Test plan
- Signed multiply:
  - Stimulus: mult a=0xFFFFFFFE (−2), b=3.
  - Response: busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged during busy.
- Unsigned multiply:
  - Stimulus: multu a=0xFFFFFFFF, b=0xFFFFFFFF.
  - Response: after 5 cycles, hi=0xFFFFFFFE, lo=0x00000001.
- Signed and unsigned divide:
  - Stimulus: div a=−7 (0xFFFFFFF9), b=2.
  - Response: busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Stimulus: divu same operands.
  - Response: lo=0x7FFFFFFC, hi=1.
- Corner cases:
  - Stimulus: divu by 0 with hi=0x11, lo=0x22.
  - Response: busy 10 cycles; hi/lo stay 0x11/0x22.
  - Stimulus: div 0x80000000 / −1.
  - Response: lo=0x80000000, hi=0.
- mthi/mtlo and ignored commands:
  - Stimulus: mthi a=0xDEADBEEF in IDLE.
  - Response: hi=0xDEADBEEF next cycle, busy never asserts.
  - Stimulus: mtlo and a second mult issued during RUN.
  - Response: ignored; the original result still lands.
- Reset mid-operation:
  - Stimulus: drop resetn at cycle 3 of a div.
  - Response: busy, hi, lo = 0 immediately and no late writeback.
  - Stimulus: a fresh mult after release.
  - Response: completes normally in 5 cycles.
